// File: rtl/colorizer_pkg.sv
// Shared constants and reset-palette helpers for the layered colorizer.
package colorizer_pkg;

  // Channel order inside a packed {R,G,B} word, most significant first.
  localparam int N_CH = 3;
  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  // Widest colour channel the helpers can build; results are truncated at use.
  localparam int MAX_COLOR_W = 16;
  localparam int MAX_RGB_W   = N_CH * MAX_COLOR_W;

  // Reset palette layout: the world palette is white at this entry; icon palettes
  // hold full red/green/blue at entries ICON_RED_IDX .. ICON_RED_IDX+2.
  localparam int WORLD_WHITE_IDX = 0;
  localparam int ICON_RED_IDX    = 1;

  // Full intensity on one channel, zero elsewhere, packed as {R,G,B}.
  function automatic logic [MAX_RGB_W-1:0] pal_full(input int ch, input int color_w);
    logic [MAX_RGB_W-1:0] ones;
    ones = (MAX_RGB_W'(1) << color_w) - MAX_RGB_W'(1);
    return ones << (color_w * (N_CH - 1 - ch));
  endfunction

  // Reset value of palette entry idx for a world or icon palette.
  function automatic logic [MAX_RGB_W-1:0] pal_reset(input logic is_world, input int idx,
                                                     input int color_w);
    if (is_world) begin
      if (idx == WORLD_WHITE_IDX)
        return pal_full(CH_R, color_w) | pal_full(CH_G, color_w) | pal_full(CH_B, color_w);
      return '0;
    end
    if (idx >= ICON_RED_IDX && idx < ICON_RED_IDX + N_CH)
      return pal_full(idx - ICON_RED_IDX, color_w);
    return '0;
  endfunction

endpackage

// File: rtl/colorizer_palette.sv
// Small palette register file: one synchronous write port, one combinational read port.
module colorizer_palette
  import colorizer_pkg::*;
#(
  parameter int PIXEL_W  = 2,
  parameter int COLOR_W  = 4,
  parameter bit IS_WORLD = 1'b0,
  localparam int RGB_W   = N_CH * COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [PIXEL_W-1:0] waddr,
  input  logic [RGB_W-1:0]   wdata,
  input  logic [PIXEL_W-1:0] raddr,
  output logic [RGB_W-1:0]   rdata
);

  localparam int DEPTH = 2 ** PIXEL_W;

  logic [RGB_W-1:0] mem [DEPTH];

  // Load default colours on reset; otherwise store one entry per write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= RGB_W'(pal_reset(IS_WORLD, i, COLOR_W));
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A lookup in the same cycle as a write sees the value before the write.
  assign rdata = mem[raddr];

endmodule

// File: rtl/layered_colorizer.sv
// Two-stage pixel colorizer: icon layers over a world layer, palette lookup,
// per-icon blink, and syncs delayed to stay aligned with the RGB output.
module layered_colorizer
  import colorizer_pkg::*;
#(
  parameter int COLOR_W      = 4,
  parameter int PIXEL_W      = 2,
  parameter int N_ICONS      = 2,
  parameter int BLINK_FRAMES = 30,
  localparam int SEL_W       = ($clog2(N_ICONS + 1) > 1) ? $clog2(N_ICONS + 1) : 1,
  localparam int RGB_W       = N_CH * COLOR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       video_on,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       frame_tick,
  input  logic [PIXEL_W-1:0]         world_pixel,
  input  logic [N_ICONS*PIXEL_W-1:0] icons,
  input  logic [N_ICONS-1:0]         blink_en,
  input  logic                       pal_we,
  input  logic [SEL_W-1:0]           pal_sel,
  input  logic [PIXEL_W-1:0]         pal_idx,
  input  logic [RGB_W-1:0]           pal_data,
  output logic [COLOR_W-1:0]         red,
  output logic [COLOR_W-1:0]         green,
  output logic [COLOR_W-1:0]         blue,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       video_on_out
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Stage 1 registers.
  logic [PIXEL_W-1:0]         s1_world;
  logic [N_ICONS*PIXEL_W-1:0] s1_icons;
  logic [N_ICONS-1:0]         s1_blink_en;
  logic                       s1_video_on;
  logic                       s1_hsync;
  logic                       s1_vsync;

  // Blink timebase.
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  // Stage 2 lookup results.
  logic [RGB_W-1:0]   world_rgb;
  logic [RGB_W-1:0]   icon_rgb [N_ICONS];
  logic [N_ICONS-1:0] visible;
  logic [RGB_W-1:0]   pick;

  // Capture the incoming pixel codes, controls and syncs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_world    <= '0;
      s1_icons    <= '0;
      s1_blink_en <= '0;
      s1_video_on <= 1'b0;
      s1_hsync    <= 1'b0;
      s1_vsync    <= 1'b0;
    end else begin
      s1_world    <= world_pixel;
      s1_icons    <= icons;
      s1_blink_en <= blink_en;
      s1_video_on <= video_on;
      s1_hsync    <= hsync_in;
      s1_vsync    <= vsync_in;
    end
  end

  // Count frames and flip the blink phase every BLINK_FRAMES ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  // World palette is write select 0.
  colorizer_palette #(
    .PIXEL_W  (PIXEL_W),
    .COLOR_W  (COLOR_W),
    .IS_WORLD (1'b1)
  ) u_world_pal (
    .clk   (clk),
    .reset (reset),
    .we    (pal_we && (pal_sel == '0)),
    .waddr (pal_idx),
    .wdata (pal_data),
    .raddr (s1_world),
    .rdata (world_rgb)
  );

  // Icon i palette is write select i+1; selects above N_ICONS match nothing.
  for (genvar g = 0; g < N_ICONS; g++) begin : g_icon_pal
    colorizer_palette #(
      .PIXEL_W  (PIXEL_W),
      .COLOR_W  (COLOR_W),
      .IS_WORLD (1'b0)
    ) u_icon_pal (
      .clk   (clk),
      .reset (reset),
      .we    (pal_we && (pal_sel == SEL_W'(g + 1))),
      .waddr (pal_idx),
      .wdata (pal_data),
      .raddr (s1_icons[g*PIXEL_W +: PIXEL_W]),
      .rdata (icon_rgb[g])
    );
  end

  // An icon shows when its code is non-transparent and it is not blanked by blink.
  always_comb begin
    visible = '0;
    for (int i = 0; i < N_ICONS; i++)
      visible[i] = (s1_icons[i*PIXEL_W +: PIXEL_W] != '0) && !(s1_blink_en[i] && blink_phase);
  end

  // Lowest-numbered visible icon wins; world colour when no icon shows.
  always_comb begin
    logic found;
    pick  = world_rgb;
    found = 1'b0;
    for (int i = 0; i < N_ICONS; i++) begin
      if (!found && visible[i]) begin
        pick  = icon_rgb[i];
        found = 1'b1;
      end
    end
  end

  // Register the colour (blanked outside the active area) and the aligned syncs.
  always_ff @(posedge clk) begin
    if (reset) begin
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      video_on_out <= 1'b0;
    end else begin
      red          <= s1_video_on ? pick[2*COLOR_W +: COLOR_W] : '0;
      green        <= s1_video_on ? pick[COLOR_W +: COLOR_W]   : '0;
      blue         <= s1_video_on ? pick[0 +: COLOR_W]         : '0;
      hsync_out    <= s1_hsync;
      vsync_out    <= s1_vsync;
      video_on_out <= s1_video_on;
    end
  end

endmodule

// File: tb/tb_layered_colorizer.sv
// Bench for layered_colorizer (COLOR_W=4, PIXEL_W=2, N_ICONS=2, BLINK_FRAMES=2).
// Expected word layout: {video_on, hsync, vsync, R, G, B}.
module tb_layered_colorizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on, hsync_in, vsync_in, frame_tick;
  logic [1:0]  world_pixel;
  logic [3:0]  icons;
  logic [1:0]  blink_en;
  logic        pal_we;
  logic [1:0]  pal_sel;
  logic [1:0]  pal_idx;
  logic [11:0] pal_data;
  logic [3:0]  red, green, blue;
  logic        hsync_out, vsync_out, video_on_out;

  logic [14:0] exp_q[$];
  logic        chk = 1'b0;
  logic        chk_d1 = 1'b0;
  logic        chk_d2 = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;

  layered_colorizer #(
    .COLOR_W      (4),
    .PIXEL_W      (2),
    .N_ICONS      (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .video_on     (video_on),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .frame_tick   (frame_tick),
    .world_pixel  (world_pixel),
    .icons        (icons),
    .blink_en     (blink_en),
    .pal_we       (pal_we),
    .pal_sel      (pal_sel),
    .pal_idx      (pal_idx),
    .pal_data     (pal_data),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .video_on_out (video_on_out)
  );

  // Clock.
  always #5 clk = ~clk;

  // Marks which output cycles carry a queued expectation (2-cycle latency).
  always @(posedge clk) begin
    chk_d1 <= chk;
    chk_d2 <= chk_d1;
  end

  // Monitor: pop and compare whenever a marked output cycle arrives.
  always @(negedge clk) begin
    if (chk_d2) begin
      logic [14:0] e, got;
      got = {video_on_out, hsync_out, vsync_out, red, green, blue};
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL pixel: queue empty, got %h", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e)
          $display("FAIL pixel #%0d: got %h required %h", n_total, got, e);
        else
          n_pass++;
      end
    end
  end

  function automatic logic [14:0] ex(input logic v, input logic h, input logic s,
                                     input logic [11:0] rgb);
    return {v, h, s, rgb};
  endfunction

  // One clock of stimulus; one-cycle strobes are cleared afterwards.
  task automatic step(input logic c, input logic [14:0] e);
    chk = c;
    if (c) exp_q.push_back(e);
    @(negedge clk);
    chk        = 1'b0;
    pal_we     = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic pix_raw(input logic v, input logic h, input logic s, input logic [1:0] w,
                         input logic [1:0] i0, input logic [1:0] i1, input logic [1:0] be,
                         input logic [14:0] e);
    video_on    = v;
    hsync_in    = h;
    vsync_in    = s;
    world_pixel = w;
    icons       = {i1, i0};
    blink_en    = be;
    step(1'b1, e);
  endtask

  task automatic pix(input logic v, input logic h, input logic s, input logic [1:0] w,
                     input logic [1:0] i0, input logic [1:0] i1, input logic [1:0] be,
                     input logic [11:0] rgb);
    pix_raw(v, h, s, w, i0, i1, be, ex(v, h, s, rgb));
  endtask

  // Sets up a palette write; the following pix call issues it in the same cycle.
  task automatic wr(input logic [1:0] sel, input logic [1:0] idx, input logic [11:0] data);
    pal_we   = 1'b1;
    pal_sel  = sel;
    pal_idx  = idx;
    pal_data = data;
  endtask

  task automatic tick();
    video_on   = 1'b0;
    frame_tick = 1'b1;
    step(1'b0, '0);
  endtask

  initial begin
    reset = 1'b1; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; frame_tick = 1'b0;
    world_pixel = '0; icons = '0; blink_en = '0;
    pal_we = 1'b0; pal_sel = '0; pal_idx = '0; pal_data = '0;
    @(negedge clk);
    step(1'b0, '0);
    step(1'b0, '0);
    // Reset state: everything zero.
    video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    step(1'b1, '0);
    step(1'b1, '0);
    reset = 1'b0;

    // Default palettes and layer priority.
    pix(1, 1, 0, 2'd0, 2'd0, 2'd0, 2'b00, 12'hFFF);
    pix(1, 0, 1, 2'd1, 2'd0, 2'd0, 2'b00, 12'h000);
    pix(1, 0, 0, 2'd0, 2'd2, 2'd1, 2'b00, 12'h0F0);
    pix(1, 0, 0, 2'd0, 2'd0, 2'd1, 2'b00, 12'hF00);
    pix(1, 0, 0, 2'd0, 2'd0, 2'd0, 2'b00, 12'hFFF);
    pix(1, 0, 0, 2'd1, 2'd0, 2'd3, 2'b00, 12'h00F);

    // World palette write; the lookup coinciding with the write sees the old entry.
    pix(1, 0, 0, 2'd2, 2'd0, 2'd0, 2'b00, 12'h000);
    wr(2'd0, 2'd2, 12'h55A);
    pix(1, 0, 0, 2'd2, 2'd0, 2'd0, 2'b00, 12'h55A);
    pix(1, 0, 0, 2'd2, 2'd0, 2'd0, 2'b00, 12'h55A);
    // Out-of-range select changes nothing.
    wr(2'd3, 2'd2, 12'hABC);
    pix(1, 0, 0, 2'd2, 2'd0, 2'd0, 2'b00, 12'h55A);
    pix(1, 0, 0, 2'd0, 2'd2, 2'd0, 2'b00, 12'h0F0);
    pix(1, 0, 0, 2'd0, 2'd0, 2'd2, 2'b00, 12'h0F0);
    // Icon 1 palette write leaves icon 0 alone.
    wr(2'd2, 2'd1, 12'h123);
    pix(1, 0, 0, 2'd0, 2'd0, 2'd1, 2'b00, 12'h123);
    pix(1, 0, 0, 2'd0, 2'd1, 2'd0, 2'b00, 12'hF00);
    // Icon 0 entry 0 is transparent whatever it holds.
    wr(2'd1, 2'd0, 12'h777);
    pix(1, 0, 0, 2'd0, 2'd0, 2'd0, 2'b00, 12'hFFF);

    // Blanking and sync alignment.
    pix(0, 1, 1, 2'd0, 2'd2, 2'd1, 2'b00, 12'h000);
    pix(0, 0, 1, 2'd3, 2'd0, 2'd0, 2'b00, 12'h000);
    pix(1, 1, 1, 2'd1, 2'd0, 2'd0, 2'b00, 12'h000);

    // Blink with a two-frame half period.
    pix(1, 0, 0, 2'd0, 2'd3, 2'd0, 2'b01, 12'h00F);
    tick(); tick();
    pix(1, 0, 0, 2'd0, 2'd3, 2'd0, 2'b01, 12'hFFF);
    pix(1, 0, 0, 2'd0, 2'd3, 2'd2, 2'b01, 12'h0F0);
    pix(1, 0, 0, 2'd0, 2'd3, 2'd0, 2'b00, 12'h00F);
    tick(); tick();
    pix(1, 0, 0, 2'd0, 2'd3, 2'd0, 2'b01, 12'h00F);
    tick(); tick();
    pix(1, 0, 0, 2'd0, 2'd3, 2'd0, 2'b01, 12'hFFF);

    // Reset in mid-stream, together with a frame tick.
    pix(1, 0, 0, 2'd0, 2'd0, 2'd0, 2'b00, 12'hFFF);
    pix_raw(1, 1, 1, 2'd0, 2'd0, 2'd0, 2'b00, '0);
    reset = 1'b1; frame_tick = 1'b1;
    step(1'b1, '0);
    reset = 1'b0;
    pix(1, 0, 0, 2'd2, 2'd0, 2'd0, 2'b00, 12'h000);
    pix(1, 0, 0, 2'd0, 2'd0, 2'd1, 2'b00, 12'hF00);
    pix(1, 0, 0, 2'd0, 2'd3, 2'd0, 2'b01, 12'h00F);
    tick();
    pix(1, 0, 0, 2'd0, 2'd3, 2'd0, 2'b01, 12'h00F);
    tick();
    pix(1, 0, 0, 2'd0, 2'd3, 2'd0, 2'b01, 12'hFFF);

    // Drain and report.
    video_on = 1'b0;
    repeat (4) step(1'b0, '0);
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
